fc_bnn_layer: RTL
=================

// Module: fc_bnn_layer
// PURPOSE
//  Parametrised binary-weight fully-connected layer: CH parallel signed input channels, NOUT neurons computed in parallel.
//  Each neuron accumulates LEN beats of CH inputs, each input multiplied by a +1/-1 weight.
//  Weights are loaded serially, 1 bit/cycle, before streaming.
//  Sits after the last conv/pool stage. Successor to the fixed 12-channel single-output FC.
//  Adds: multi-neuron, ready/valid backpressure, reloadable weights, sign-activation mode.
// PARAMETERS
//  CH    12  input channels per beat
//  DW    32  signed input width
//  LEN   16  beats per inference (CH*LEN = 192 inputs per neuron)
//  NOUT  10  neurons (outputs)
//  ACCW  DW+$clog2(CH*LEN) (=40)  accumulator/output width per neuron
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset. One clock; reset is asynchronous and active-high.
//  weight_en  in   1          serial weight bit valid
//  weight     in   1          weight bit: 1 => +x, 0 => -x
//  ivalid     in   1          din beat valid
//  iready     out  1          beat accepted when ivalid&iready
//  din        in   CH*DW      channel c at [c*DW +: DW], signed
//  act_sign   in   1          1: dout[n] = sign flag; 0: raw sum. Sampled at last beat
//  ovalid     out  1          dout valid, held until oready
//  oready     in   1          downstream accepts dout
//  dout       out  NOUT*ACCW  neuron n at [n*ACCW +: ACCW], signed
//  wloaded    out  1          full weight set present
//  werr       out  1          sticky: weight_en seen in RUN/OUT
// BEHAVIOUR
//  Reset (async, active-high):
//   - outputs: iready=0, ovalid=0, dout=0, wloaded=0, werr=0.
//   - weight store, counters and accumulators cleared; state=IDLE.
//  Weight load:
//   - Order is neuron-major, then beat, then channel: bit k -> n=k/(CH*LEN), b=(k/CH)%LEN, c=k%CH.
//   - Each cycle with weight_en=1 in IDLE/LOAD stores one bit and increments wcnt.
//   - weight_en low mid-load pauses; the counter holds.
//   - wcnt==NOUT*CH*LEN-1 accepted -> wloaded=1 next cycle, state IDLE.
//   - weight_en in IDLE while wloaded=1 restarts at k=0 and clears wloaded.
//   - weight_en in RUN/OUT is ignored and sets werr (cleared only by rst).
//  FSM: IDLE -> LOAD on weight_en. IDLE -> RUN on first accepted beat (wloaded=1).
//   RUN -> OUT after the LEN-th beat. OUT -> IDLE on ovalid&oready.
//  iready = wloaded & ~weight_en & state in {IDLE,RUN}; 0 in LOAD/OUT.
//  Per accepted beat b:
//   - acc[n] += sum_c (w[n][b][c] ? din_c : -din_c), sign-extended to ACCW.
//   - -(-2^(DW-1)) is computed in ACCW, so it does not wrap.
//   - Beat 0 loads acc instead of adding.
//  Latency: ovalid=1 the cycle after the LEN-th beat. dout is registered and stable while ovalid=1 & oready=0.
//  act_sign=1: dout[n] = {ACCW-1 zeros, (sum>=0)}.
//  ivalid while iready=0 is not consumed; the source must hold it.
//  ovalid&oready is a single cycle; the next beat can be accepted one cycle later (back-to-back).
// STRUCTURE
//  Package fc_bnn_pkg:
//   - state enum {IDLE,LOAD,RUN,OUT}
//   - function acc_width(DW,CH,LEN)
//   - weight index function.
//  Sub-module bnn_pm_sum (CH inputs, DW->ACCW):
//   - +/- select plus adder tree for one neuron; generated NOUT times.
//  Top holds the weight store, counters, FSM and accumulators.
// TESTING (defaults CH=12, LEN=16, NOUT=10)
//  1 Weights all 1, din all 1, act_sign=0:
//    - every dout[n]=192.
//    - ovalid rises exactly 1 cycle after the 16th beat.
//  2 Weights all 0, din all 5: every dout[n]=-960. With act_sign=1: dout[n]=0.
//  3 Neuron n weights =1 only for channel n%12, din_c=-2^31:
//    - dout[n] = -2^31*16 + 2^31*176 = 343597383680.
//    - no wrap at ACCW=40.
//  4 oready=0 for 5 cycles after ovalid:
//    - dout stable, iready=0.
//    - the handshake ends OUT; a new stream is accepted the next cycle.
//  5 rst after beat 7 of RUN:
//    - all outputs 0, wloaded=0, iready=0.
//    - after reload, a full stream gives correct sums.
//  6 weight_en pulsed during RUN: werr=1, sums unchanged. Mid-load weight_en gaps do not corrupt weights.

Source files
------------

// File: rtl/fc_bnn_pkg.sv
// Shared types and helpers for the binary-weight fully-connected layer.
package fc_bnn_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

   function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ch,
                                             input int unsigned len);
      return dw + $clog2(ch * len);
   endfunction

   // Flat weight-store index: neuron-major, then beat, then channel.
   function automatic int unsigned widx(input int unsigned n, input int unsigned b,
                                        input int unsigned c, input int unsigned ch,
                                        input int unsigned len);
      return (n * len + b) * ch + c;
   endfunction

endpackage

// File: rtl/bnn_pm_sum.sv
// One neuron's beat contribution: each channel added or subtracted by its weight bit,
// sign-extended to ACCW before negation so the most negative input cannot wrap.
module bnn_pm_sum #(
   parameter int unsigned CH   = 12,
   parameter int unsigned DW   = 32,
   parameter int unsigned ACCW = 40
) (
   input  logic [CH-1:0]          i_w,
   input  logic [CH*DW-1:0]       i_din,
   output logic signed [ACCW-1:0] o_sum_c
);

   logic signed [ACCW-1:0] w_term [CH];

   for (genvar c = 0; c < CH; c++) begin : g_term
      logic signed [DW-1:0] w_x;
      assign w_x       = i_din[c*DW +: DW];
      assign w_term[c] = i_w[c] ? ACCW'(w_x) : -ACCW'(w_x);
   end

   always_comb begin
      o_sum_c = '0;
      for (int c = 0; c < CH; c++) begin
         o_sum_c = o_sum_c + w_term[c];
      end
   end

endmodule

// File: rtl/fc_bnn_layer.sv
// Binary-weight fully-connected layer: serial weight load, NOUT neurons accumulating
// LEN beats of CH signed channels, ready/valid on both sides, optional sign activation.
module fc_bnn_layer
   import fc_bnn_pkg::*;
#(
   parameter int unsigned  CH   = 12,
   parameter int unsigned  DW   = 32,
   parameter int unsigned  LEN  = 16,
   parameter int unsigned  NOUT = 10,
   localparam int unsigned ACCW = acc_width(DW, CH, LEN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 weight_en,
   input  logic                 weight,
   input  logic                 ivalid,
   output logic                 iready,
   input  logic [CH*DW-1:0]     din,
   input  logic                 act_sign,
   output logic                 ovalid,
   input  logic                 oready,
   output logic [NOUT*ACCW-1:0] dout,
   output logic                 wloaded,
   output logic                 werr
);

   localparam int unsigned NW  = NOUT * CH * LEN;
   localparam int unsigned WCW = (NW > 1) ? $clog2(NW) : 1;
   localparam int unsigned BW  = (LEN > 1) ? $clog2(LEN) : 1;

   state_t         r_state, w_state_nxt;
   logic [NW-1:0]  r_w;
   logic [WCW-1:0] r_wcnt;
   logic [BW-1:0]  r_beat;
   logic           r_ovalid, r_wloaded, r_werr;
   logic           w_wr, w_take, w_werr_set, w_ohs, w_wlast, w_blast;

   assign w_wlast = (r_wcnt == WCW'(NW - 1));
   assign w_blast = (r_beat == BW'(LEN - 1));
   assign iready  = r_wloaded & ~weight_en & ((r_state == IDLE) | (r_state == RUN));
   assign ovalid  = r_ovalid;
   assign wloaded = r_wloaded;
   assign werr    = r_werr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and per-cycle strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_wr        = 1'b0;
      w_take      = 1'b0;
      w_werr_set  = 1'b0;
      w_ohs       = 1'b0;
      case (r_state)
         IDLE: begin
            if (weight_en) begin
               w_wr        = 1'b1;
               w_state_nxt = w_wlast ? IDLE : LOAD;
            end else if (ivalid && iready) begin
               w_take      = 1'b1;
               w_state_nxt = w_blast ? OUT : RUN;
            end
         end
         LOAD: begin
            if (weight_en) begin
               w_wr = 1'b1;
               if (w_wlast) w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (weight_en) begin
               w_werr_set = 1'b1;
            end else if (ivalid && iready) begin
               w_take = 1'b1;
               if (w_blast) w_state_nxt = OUT;
            end
         end
         OUT: begin
            w_werr_set = weight_en;
            if (oready) begin
               w_ohs       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A completed load leaves wcnt at 0, so a reload in IDLE restarts at bit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w       <= '0;
         r_wcnt    <= '0;
         r_wloaded <= 1'b0;
         r_werr    <= 1'b0;
         r_beat    <= '0;
         r_ovalid  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_w[r_wcnt] <= weight;
            r_wcnt      <= w_wlast ? '0 : r_wcnt + WCW'(1);
            r_wloaded   <= w_wlast;
         end
         if (w_werr_set) r_werr <= 1'b1;
         if (w_take) r_beat <= w_blast ? '0 : r_beat + BW'(1);
         if (w_take && w_blast) r_ovalid <= 1'b1;
         else if (w_ohs)        r_ovalid <= 1'b0;
      end
   end

   for (genvar n = 0; n < NOUT; n++) begin : g_neuron
      logic [WCW-1:0]         w_base;
      logic signed [ACCW-1:0] w_psum, w_sum, r_acc;
      logic [ACCW-1:0]        r_dout;

      assign w_base = WCW'(widx(n, 32'(r_beat), 0, CH, LEN));

      bnn_pm_sum #(.CH(CH), .DW(DW), .ACCW(ACCW)) u_pm_sum (
         .i_w     (r_w[w_base +: CH]),
         .i_din   (din),
         .o_sum_c (w_psum)
      );

      // Beat 0 starts a fresh sum rather than adding to the previous inference.
      assign w_sum = (r_beat == '0) ? w_psum : r_acc + w_psum;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_acc  <= '0;
            r_dout <= '0;
         end else if (w_take) begin
            r_acc <= w_sum;
            if (w_blast) r_dout <= act_sign ? {{(ACCW-1){1'b0}}, ~w_sum[ACCW-1]} : w_sum;
         end
      end

      assign dout[n*ACCW +: ACCW] = r_dout;
   end

endmodule
